psum_route_demux: RTL and testbench

Clocked, parametrised successor to the psum-adder depacketizer. Accepts packets from the NoC ingress, extracts the partial sum and source address, looks the source up in a programmable route table and pushes the psum into one of NCH per-channel FIFOs feeding the adder's PE queues. Unmapped sources are dropped and counted instead of silently stalling. Sits between the router ejection port and the psum adder input queues.

---
 rtl/psum_route_demux.sv | 126 ++++++++++++
 tb/tb_psum_route_demux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_route_demux.sv
// Routes NoC psum packets into NCH per-channel FIFOs using a programmable
// source->channel table. Packets from unmapped sources are dropped and counted.
module psum_route_demux #(
   parameter int DWIDTH     = 8,
   parameter int PWIDTH     = 47,
   parameter int SRC_LSB    = 40,
   parameter int SRC_W      = 3,
   parameter int NCH        = 3,
   parameter int DEPTH      = 4,
   parameter bit LEGACY_MAP = 1'b1,
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PWIDTH-1:0]       in_packet,
   input  logic                    cfg_we,
   input  logic [SRC_W-1:0]        cfg_src,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic                    cfg_en,
   output logic [NCH-1:0]          out_valid,
   input  logic [NCH-1:0]          out_ready,
   output logic [NCH*DWIDTH-1:0]   out_data,
   output logic [15:0]             drop_count,
   output logic                    err
);
   localparam int NSRC = 1 << SRC_W;
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = AW + 1;

   logic            tbl_en [NSRC];
   logic [CH_W-1:0] tbl_ch [NSRC];

   logic [SRC_W-1:0] src;
   logic             hit_en;
   logic [CH_W-1:0]  hit_ch;
   logic             routed;
   logic             tgt_full;
   logic             accept;
   logic [NCH-1:0]   full;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;

   assign src    = in_packet[SRC_LSB +: SRC_W];
   assign hit_en = tbl_en[src];
   assign hit_ch = tbl_ch[src];
   assign routed = hit_en && (int'(hit_ch) < NCH);

   always_comb begin
      tgt_full = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (hit_ch == CH_W'(k)) tgt_full = full[k];
      end
   end

   // Handshake: every port transfers on valid & ready at a rising edge. Ingress is
   // ready for drops, or when the target FIFO is not full before this edge's pop,
   // so a full target stalls all ingress (head-of-line blocking).
   assign in_ready = !rst && (!routed || !tgt_full);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NSRC; s++) begin
            tbl_en[s] <= 1'b0;
            tbl_ch[s] <= '0;
         end
         if (LEGACY_MAP && NCH >= 3 && NSRC >= 4) begin
            tbl_en[3] <= 1'b1;
            tbl_ch[3] <= CH_W'(0);
            tbl_en[1] <= 1'b1;
            tbl_ch[1] <= CH_W'(1);
            tbl_en[0] <= 1'b1;
            tbl_ch[0] <= CH_W'(2);
         end
      end else if (cfg_we) begin
         tbl_en[cfg_src] <= cfg_en;
         tbl_ch[cfg_src] <= cfg_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
         err        <= 1'b0;
      end else if (accept && !routed) begin
         err <= 1'b1;
         if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DWIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]     wr_ptr;
      logic [AW-1:0]     rd_ptr;
      logic [CW-1:0]     count;

      assign full[k]      = (count == CW'(DEPTH));
      assign out_valid[k] = (count != '0);
      assign push[k]      = accept && routed && (hit_ch == CH_W'(k));
      assign pop[k]       = out_valid[k] && out_ready[k];
      // Head is masked so a reset FIFO shows zero regardless of stale storage.
      assign out_data[k*DWIDTH +: DWIDTH] = out_valid[k] ? mem[rd_ptr] : '0;

      always_ff @(posedge clk) begin
         if (push[k]) mem[wr_ptr] <= in_packet[DWIDTH-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[k]) wr_ptr <= wr_ptr + AW'(1);
            if (pop[k])  rd_ptr <= rd_ptr + AW'(1);
            case ({push[k], pop[k]})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_psum_route_demux.sv
// Directed bench for psum_route_demux: a default NCH=3 instance with a per-channel
// expected-queue scoreboard, plus an NCH=5 instance for the wide-channel table case.
module tb_psum_route_demux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv3, ir3, cw3, ce3, er3;
   logic [46:0] ip3;
   logic [2:0]  cs3, ov3, or3;
   logic [1:0]  cc3;
   logic [23:0] od3;
   logic [15:0] dc3;

   logic        iv5, ir5, cw5, ce5, er5;
   logic [46:0] ip5;
   logic [2:0]  cs5, cc5;
   logic [4:0]  ov5, or5;
   logic [39:0] od5;
   logic [15:0] dc5;

   int checks = 0;
   int errors = 0;
   int w;
   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] exp_q2[$];

   psum_route_demux u_dut3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_packet(ip3),
      .cfg_we(cw3), .cfg_src(cs3), .cfg_ch(cc3), .cfg_en(ce3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3), .drop_count(dc3), .err(er3)
   );

   psum_route_demux #(.NCH(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_packet(ip5),
      .cfg_we(cw5), .cfg_src(cs5), .cfg_ch(cc5), .cfg_en(ce5),
      .out_valid(ov5), .out_ready(or5), .out_data(od5), .drop_count(dc5), .err(er5)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Random filler in the ignored packet bits.
   function automatic logic [46:0] pkt(input logic [2:0] s, input logic [7:0] p);
      logic [46:0] v;
      v = {15'($urandom), 32'($urandom)};
      v[42:40] = s;
      v[7:0]   = p;
      return v;
   endfunction

   // Drives one packet into the NCH=3 instance; ch 0..2 = expected channel, 3 = drop.
   task automatic send3(input logic [2:0] s, input logic [7:0] p, input int ch,
                        output int waited);
      iv3 = 1'b1;
      ip3 = pkt(s, p);
      #1;
      waited = 0;
      while (!ir3 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("send accept", 64'(ir3), 64'd1);
      @(posedge clk); #1;
      iv3 = 1'b0;
      case (ch)
         0:       exp_q0.push_back(p);
         1:       exp_q1.push_back(p);
         2:       exp_q2.push_back(p);
         default: ;
      endcase
   endtask

   task automatic cfg5(input logic [2:0] s, input logic [2:0] c, input logic e);
      cw5 = 1'b1; cs5 = s; cc5 = c; ce5 = e;
      @(posedge clk); #1;
      cw5 = 1'b0;
   endtask

   // Scoreboard: every pop on the NCH=3 instance must match the expected queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (ov3[0] && or3[0]) begin
            chk("ch0 pop expected", 64'(exp_q0.size() != 0), 64'd1);
            if (exp_q0.size() != 0) chk("ch0 data", 64'(od3[7:0]), 64'(exp_q0.pop_front()));
         end
         if (ov3[1] && or3[1]) begin
            chk("ch1 pop expected", 64'(exp_q1.size() != 0), 64'd1);
            if (exp_q1.size() != 0) chk("ch1 data", 64'(od3[15:8]), 64'(exp_q1.pop_front()));
         end
         if (ov3[2] && or3[2]) begin
            chk("ch2 pop expected", 64'(exp_q2.size() != 0), 64'd1);
            if (exp_q2.size() != 0) chk("ch2 data", 64'(od3[23:16]), 64'(exp_q2.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iv3 = 0; ip3 = '0; cw3 = 0; cs3 = '0; cc3 = '0; ce3 = 0; or3 = '0;
      iv5 = 0; ip5 = '0; cw5 = 0; cs5 = '0; cc5 = '0; ce5 = 0; or5 = '0;

      // Reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      iv3 = 1'b1; ip3 = pkt(3'd3, 8'hEE);
      #1;
      chk("rst in_ready", 64'(ir3), 64'd0);
      chk("rst out_valid", 64'(ov3), 64'd0);
      chk("rst out_data", 64'(od3), 64'd0);
      chk("rst drop_count", 64'(dc3), 64'd0);
      chk("rst err", 64'(er3), 64'd0);
      iv3 = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Legacy map, one-cycle latency
      or3 = 3'b111;
      send3(3'd3, 8'h11, 0, w);
      chk("legacy ch0 valid", 64'(ov3), 64'b001);
      chk("legacy ch0 data", 64'(od3[7:0]), 64'h11);
      send3(3'd1, 8'h22, 1, w);
      chk("legacy ch1 valid", 64'(ov3), 64'b010);
      chk("legacy ch1 data", 64'(od3[15:8]), 64'h22);
      send3(3'd0, 8'h33, 2, w);
      chk("legacy ch2 valid", 64'(ov3), 64'b100);
      chk("legacy ch2 data", 64'(od3[23:16]), 64'h33);
      chk("legacy drops", 64'(dc3), 64'd0);
      @(posedge clk); #1;
      chk("legacy drained", 64'(ov3), 64'd0);

      // Unmapped sources
      send3(3'd5, 8'h44, 3, w);
      chk("drop no stall", 64'(w), 64'd0);
      chk("drop no valid", 64'(ov3), 64'd0);
      chk("drop count 1", 64'(dc3), 64'd1);
      chk("drop err", 64'(er3), 64'd1);
      send3(3'd7, 8'h55, 3, w);
      chk("drop count 2", 64'(dc3), 64'd2);
      chk("drop err sticky", 64'(er3), 64'd1);

      // Backpressure on ch0, full FIFO
      or3 = 3'b110;
      for (int i = 1; i <= 4; i++) send3(3'd3, 8'(i), 0, w);
      chk("full valid", 64'(ov3), 64'b001);
      chk("full head", 64'(od3[7:0]), 64'h01);
      iv3 = 1'b1; ip3 = pkt(3'd3, 8'h05);
      #1;
      chk("full stall", 64'(ir3), 64'd0);
      @(posedge clk); #1;
      chk("full stall held", 64'(ir3), 64'd0);
      chk("full head stable", 64'(od3[7:0]), 64'h01);
      or3[0] = 1'b1;
      #1;
      chk("full before pop", 64'(ir3), 64'd0);
      @(posedge clk); #1;
      chk("ready after pop", 64'(ir3), 64'd1);
      @(posedge clk); #1;
      iv3 = 1'b0;
      exp_q0.push_back(8'h05);
      repeat (6) @(posedge clk);
      #1;
      chk("full drained", 64'(exp_q0.size()), 64'd0);
      chk("full idle", 64'(ov3), 64'd0);

      // Remap in the same cycle as a packet from that source
      cw3 = 1'b1; cs3 = 3'd3; cc3 = 2'd2; ce3 = 1'b1;
      send3(3'd3, 8'hA0, 0, w);
      cw3 = 1'b0;
      chk("remap old entry", 64'(ov3), 64'b001);
      chk("remap old data", 64'(od3[7:0]), 64'hA0);
      send3(3'd3, 8'hA1, 2, w);
      chk("remap new entry", 64'(ov3), 64'b100);
      chk("remap new data", 64'(od3[23:16]), 64'hA1);
      @(posedge clk); #1;

      // Five-channel instance: valid high channel, out-of-range channel
      cfg5(3'd6, 3'd4, 1'b1);
      cfg5(3'd2, 3'd7, 1'b1);
      iv5 = 1'b1; ip5 = pkt(3'd6, 8'h66);
      #1;
      chk("nch5 ready ch4", 64'(ir5), 64'd1);
      @(posedge clk); #1;
      iv5 = 1'b0;
      chk("nch5 ch4 valid", 64'(ov5), 64'b10000);
      chk("nch5 ch4 data", 64'(od5[39:32]), 64'h66);
      iv5 = 1'b1; ip5 = pkt(3'd2, 8'h77);
      #1;
      chk("nch5 ready drop", 64'(ir5), 64'd1);
      @(posedge clk); #1;
      iv5 = 1'b0;
      chk("nch5 drop count", 64'(dc5), 64'd1);
      chk("nch5 err", 64'(er5), 64'd1);
      chk("nch5 no new valid", 64'(ov5), 64'b10000);
      chk("nch5 data stable", 64'(od5[39:32]), 64'h66);

      // Reset mid-traffic
      or3 = 3'b000;
      send3(3'd1, 8'h61, 1, w);
      send3(3'd1, 8'h62, 1, w);
      send3(3'd1, 8'h63, 1, w);
      chk("pre-rst valid", 64'(ov3), 64'b010);
      chk("pre-rst head", 64'(od3[15:8]), 64'h61);
      exp_q1.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid-rst out_valid", 64'(ov3), 64'd0);
      chk("mid-rst out_data", 64'(od3), 64'd0);
      chk("mid-rst drop_count", 64'(dc3), 64'd0);
      chk("mid-rst err", 64'(er3), 64'd0);
      or3 = 3'b111;
      send3(3'd1, 8'h5A, 1, w);
      chk("post-rst ch1 only", 64'(ov3), 64'b010);
      chk("post-rst ch1 data", 64'(od3[15:8]), 64'h5A);
      send3(3'd3, 8'h5B, 0, w);
      chk("post-rst legacy src3", 64'(ov3), 64'b001);
      chk("post-rst src3 data", 64'(od3[7:0]), 64'h5B);
      repeat (3) @(posedge clk);
      #1;
      chk("final queues empty", 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
      chk("final idle", 64'(ov3), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
